seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle ALU for the next-generation datapath. It extends the single-cycle ADD/SUB/AND/ORR/EOR unit with an iterative unsigned multiply (double-width product) and an unsigned divide (quotient and remainder). Operations are issued through a start/busy/done handshake and produce registered NZCV flags. The block sits beside the register file in the execute stage, and the controller stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width (≥ 4).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  issue request; sampled only while `busy`=0.
- `op`  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 UDIV, 111 reserved.
- `src_a`  in  WIDTH  operand A (dividend for UDIV).
- `src_b`  in  WIDTH  operand B (divisor for UDIV).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when results update.
- `result`  out  WIDTH  ALU result, product low word, or quotient.
- `result_hi`  out  WIDTH  product high word (MUL), remainder (UDIV), else 0.
- `flags`  out  4  {N,Z,C,V}.
- `div_by_zero`  out  1  set with `done` for UDIV with `src_b`=0, else 0.

## Operation
- FSM states:
  - IDLE: `busy`=0. On `start`, latch `op`, `src_a` and `src_b`, then go to RUN.
  - RUN: `busy`=1. A count register is loaded with 1 for ADD/SUB/logic/reserved ops and with WIDTH for MUL/UDIV. It decrements each cycle. On the last count, write `result`, `result_hi`, `flags` and `div_by_zero`, pulse `done`, and go to IDLE.
- ADD/SUB:
  - Computed at WIDTH+1 bits; SUB is A + ~B + 1.
  - C = carry out of bit WIDTH-1. For SUB, C=1 means no borrow.
  - V = signed overflow: operand signs (B inverted for SUB) agree and the result sign differs.
- AND/ORR/EOR: bitwise; C=0, V=0.
- MUL: unsigned shift-add, one bit of `src_b` per RUN cycle, 2·WIDTH product → {`result_hi`,`result`}; C=0, V=0.
- UDIV:
  - Restoring division, one quotient bit per cycle.
  - Divisor 0: `result`=all-ones, `result_hi`=`src_a`, `div_by_zero`=1; still takes WIDTH cycles.
  - C=0, V=0.
- Reserved op: `result`=0, `result_hi`=0, flags=0100.
- N = `result`[WIDTH-1] and Z = (`result`==0) for every op.
- `start` while `busy`=1 is ignored; the in-flight op completes unaffected.
- Outputs hold their values until the next `done`.

## Timing
- Reset value of every output is 0, including `flags`=0000; the FSM resets to IDLE. Reset mid-operation aborts the op with no `done`.
- Let `start` be sampled at edge t0:
  - `busy`=1 from t0 until edge t0+L, where L=1 for simple ops and L=WIDTH for MUL/UDIV.
  - At edge t0+L, the result registers update, `done`=1 and `busy`=0 for exactly one cycle.
- Back-to-back issue: `start` may be high during the `done` cycle and is accepted at that edge. Peak throughput is one simple op per cycle.
- Operand inputs may change after t0 without effect.
- No combinational path exists from inputs to any output.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `result` 0x80000000, flags 1001, `done` one cycle after `start`.
- SUB 5−5 → `result` 0, flags 0110. SUB 3−5 → `result` 0xFFFFFFFE, flags 1000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF:
  - `result_hi` 0xFFFFFFFE, `result` 0x00000001.
  - `done` exactly 32 cycles after `start`.
  - A second `start` pulsed mid-op is ignored.
- UDIV 100/7 → `result` 14, `result_hi` 2, `div_by_zero` 0. UDIV 0x1234/0 → `result` 0xFFFFFFFF, `result_hi` 0x1234, `div_by_zero` 1.
- Assert `reset_n` low at cycle 10 of a MUL → all outputs 0 immediately with no `done`. After release, ADD 2+2 → 4.
- ADD, EOR and AND issued on consecutive `done` cycles → three `done` pulses on consecutive cycles, each with correct results. Repeat all cases with WIDTH=8: 0x7F+0x01 → 0x80, flags 1001.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, shift-add MUL and restoring UDIV.
// Start/busy/done handshake with registered result and NZCV flags.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic [3:0]       flags_q, flags_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   add_sum;

  logic [WIDTH-1:0] res_w;
  logic [WIDTH-1:0] rhi_w;
  logic             c_w;
  logic             v_w;
  logic             dbz_w;

  logic last;
  logic accept;
  logic is_long;

  // The op completes on the last count; a new op may be taken on that same edge.
  assign last    = (state_q == S_RUN) && (cnt_q == CW'(1));
  assign accept  = start && ((state_q == S_IDLE) || last);
  assign is_long = (op == OP_MUL) || (op == OP_DIV);

  // One iteration of shift-add multiply, restoring divide and the adder.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh - {1'b0, b_q};
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo  = {lo_q[WIDTH-2:0], div_ge};
    b_op     = (op_q == OP_SUB) ? ~b_q : b_q;
    add_sum  = {1'b0, a_q} + {1'b0, b_op}
             + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
  end

  // Final result selection for the op completing this cycle.
  always_comb begin
    res_w = '0;
    rhi_w = '0;
    c_w   = 1'b0;
    v_w   = 1'b0;
    dbz_w = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD) || (op_q == OP_SUB): begin
        res_w = add_sum[WIDTH-1:0];
        c_w   = add_sum[WIDTH];
        v_w   = (a_q[WIDTH-1] == b_op[WIDTH-1])
             && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      (op_q == OP_AND): res_w = a_q & b_q;
      (op_q == OP_ORR): res_w = a_q | b_q;
      (op_q == OP_EOR): res_w = a_q ^ b_q;
      (op_q == OP_MUL): begin
        res_w = {mul_sum[0], lo_q[WIDTH-1:1]};
        rhi_w = mul_sum[WIDTH:1];
      end
      (op_q == OP_DIV): begin
        res_w = div_quo;
        rhi_w = div_rem;
        dbz_w = (b_q == '0);
      end
      default: ;
    endcase
  end

  // FSM next state, iteration registers and output register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    rhi_d   = rhi_q;
    flags_d = flags_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end else if (op_q == OP_DIV) begin
        hi_d = div_rem;
        lo_d = div_quo;
      end
      if (last) begin
        res_d   = res_w;
        rhi_d   = rhi_w;
        flags_d = {res_w[WIDTH-1], ~|res_w, c_w, v_w};
        dbz_d   = dbz_w;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
    if (accept) begin
      state_d = S_RUN;
      op_d    = op;
      a_d     = src_a;
      b_d     = src_b;
      hi_d    = '0;
      lo_d    = (op == OP_DIV) ? src_a : src_b;
      cnt_d   = is_long ? CW'(WIDTH) : CW'(1);
    end
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      rhi_q   <= '0;
      flags_q <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      rhi_q   <= rhi_d;
      flags_q <= flags_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign result      = res_q;
  assign result_hi   = rhi_q;
  assign flags       = flags_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=32 and WIDTH=8.
// Each scenario task drives stimulus and compares inline.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start8;
  logic [2:0]  op, op8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;

  logic        busy, done, dbz;
  logic [31:0] res, rhi;
  logic [3:0]  flg;
  logic        busy8, done8, dbz8;
  logic [7:0]  res8, rhi8;
  logic [3:0]  flg8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(a), .src_b(b), .busy(busy), .done(done),
    .result(res), .result_hi(rhi), .flags(flg),
    .div_by_zero(dbz)
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8),
    .src_a(a8), .src_b(b8), .busy(busy8), .done(done8),
    .result(res8), .result_hi(rhi8), .flags(flg8),
    .div_by_zero(dbz8)
  );

  // Issue one op on the 32-bit unit; lat = edges from issue to done, -1 on timeout.
  task automatic do_op32(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
      lat++;
    end while (done !== 1'b1 && lat < 100);
    lat = (done === 1'b1) ? lat - 1 : -1;
  endtask

  task automatic do_op8(input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, output int lat);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    lat = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
      lat++;
    end while (done8 !== 1'b1 && lat < 100);
    lat = (done8 === 1'b1) ? lat - 1 : -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; start8 = 1'b0;
    op = '0; op8 = '0; a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, dbz, flg} !== 7'd0) begin errors++; $display("FAIL rst_ctl32: got %b exp 0000000", {busy, done, dbz, flg}); end
    checks++; if ({res, rhi} !== 64'd0) begin errors++; $display("FAIL rst_res32: got %h exp 0", {res, rhi}); end
    checks++; if ({busy8, done8, dbz8, flg8, res8, rhi8} !== 23'd0) begin errors++; $display("FAIL rst_w8: got %h exp 0", {busy8, done8, dbz8, flg8, res8, rhi8}); end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    do_op32(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d exp 1", lat); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL add_res: got %h exp 80000000", res); end
    checks++; if (flg !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b exp 1001", flg); end
    checks++; if ({rhi, dbz, busy} !== 34'd0) begin errors++; $display("FAIL add_hi: got %h exp 0", {rhi, dbz, busy}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_pulse: got %b exp 0", done); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL add_hold: got %h exp 80000000", res); end
    do_op32(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++; if ({res, flg} !== {32'h0, 4'b0110}) begin errors++; $display("FAIL add_carry: got %h/%b exp 0/0110", res, flg); end
  endtask

  task automatic test_sub();
    int lat;
    do_op32(3'b001, 32'd5, 32'd5, lat);
    checks++; if ({res, flg} !== {32'h0, 4'b0110}) begin errors++; $display("FAIL sub_eq: got %h/%b exp 0/0110", res, flg); end
    do_op32(3'b001, 32'd3, 32'd5, lat);
    checks++; if ({res, flg} !== {32'hFFFF_FFFE, 4'b1000}) begin errors++; $display("FAIL sub_neg: got %h/%b exp fffffffe/1000", res, flg); end
    do_op32(3'b001, 32'h8000_0000, 32'd1, lat);
    checks++; if ({res, flg} !== {32'h7FFF_FFFF, 4'b0011}) begin errors++; $display("FAIL sub_ovf: got %h/%b exp 7fffffff/0011", res, flg); end
  endtask

  task automatic test_logic();
    int lat;
    do_op32(3'b010, 32'hF0F0_00FF, 32'h0FF0_FF0F, lat);
    checks++; if ({res, flg} !== {32'h00F0_000F, 4'b0000}) begin errors++; $display("FAIL and: got %h/%b exp 00f0000f/0000", res, flg); end
    do_op32(3'b011, 32'h0, 32'h0, lat);
    checks++; if ({res, flg} !== {32'h0, 4'b0100}) begin errors++; $display("FAIL orr_zero: got %h/%b exp 0/0100", res, flg); end
    do_op32(3'b011, 32'h1200_0000, 32'h0000_0034, lat);
    checks++; if ({res, flg} !== {32'h1200_0034, 4'b0000}) begin errors++; $display("FAIL orr: got %h/%b exp 12000034/0000", res, flg); end
    do_op32(3'b100, 32'h8000_0001, 32'h0000_0001, lat);
    checks++; if ({res, flg} !== {32'h8000_0000, 4'b1000}) begin errors++; $display("FAIL eor: got %h/%b exp 80000000/1000", res, flg); end
    do_op32(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if ({res, rhi, flg, lat} !== {64'h0, 4'b0100, 32'd1}) begin errors++; $display("FAIL rsvd: got %h/%h/%b/%0d exp 0/0/0100/1", res, rhi, flg, lat); end
  endtask

  task automatic test_mul();
    int lat;
    int late_done;
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == 10);
      op = (lat == 10) ? 3'b000 : 3'($urandom);
      a = $urandom; b = $urandom;
    end while (done !== 1'b1 && lat < 100);
    start = 1'b0;
    lat = (done === 1'b1) ? lat - 1 : -1;
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul_lat: got %0d exp 32", lat); end
    checks++; if (rhi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_hi: got %h exp fffffffe", rhi); end
    checks++; if ({res, flg} !== {32'h1, 4'b0000}) begin errors++; $display("FAIL mul_lo: got %h/%b exp 1/0000", res, flg); end
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL mul_ignore: got %0d extra busy/done cycles exp 0", late_done); end
    do_op32(3'b101, 32'h0001_0000, 32'h0001_0000, lat);
    checks++; if ({rhi, res, flg} !== {32'h1, 32'h0, 4'b0100}) begin errors++; $display("FAIL mul_z: got %h_%h/%b exp 1_0/0100", rhi, res, flg); end
    do_op32(3'b101, 32'd12345, 32'd678, lat);
    checks++; if ({rhi, res} !== {32'h0, 32'd8369910}) begin errors++; $display("FAIL mul_small: got %h_%h exp 0_%h", rhi, res, 32'd8369910); end
  endtask

  task automatic test_div();
    int lat;
    do_op32(3'b110, 32'd100, 32'd7, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div_lat: got %0d exp 32", lat); end
    checks++; if ({res, rhi, dbz, flg} !== {32'd14, 32'd2, 1'b0, 4'b0000}) begin errors++; $display("FAIL div: got %0d r%0d z%b %b exp 14 r2 z0 0000", res, rhi, dbz, flg); end
    do_op32(3'b110, 32'd3, 32'd9, lat);
    checks++; if ({res, rhi, flg} !== {32'd0, 32'd3, 4'b0100}) begin errors++; $display("FAIL div_small: got %0d r%0d %b exp 0 r3 0100", res, rhi, flg); end
    do_op32(3'b110, 32'h1234, 32'd0, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div0_lat: got %0d exp 32", lat); end
    checks++; if ({res, rhi, dbz, flg} !== {32'hFFFF_FFFF, 32'h1234, 1'b1, 4'b1000}) begin errors++; $display("FAIL div0: got %h r%h z%b %b exp ffffffff r1234 z1 1000", res, rhi, dbz, flg); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'hFFFF_FFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b exp 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if ({res, rhi, flg, dbz, busy, done} !== 71'd0) begin errors++; $display("FAIL rmid_clear: got %h exp 0", {res, rhi, flg, dbz, busy, done}); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d busy/done cycles exp 0", seen); end
    do_op32(3'b000, 32'd2, 32'd2, lat);
    checks++; if ({res, flg, lat} !== {32'd4, 4'b0000, 32'd1}) begin errors++; $display("FAIL rmid_add: got %0d/%b/%0d exp 4/0000/1", res, flg, lat); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd1; b = 32'd2;
    @(negedge clk);
    op = 3'b100; a = 32'h0000_FF00; b = 32'h0000_0F0F;
    @(negedge clk);
    checks++; if ({done, res} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_add: got %b/%h exp 1/3", done, res); end
    op = 3'b010; a = 32'h0000_F0F0; b = 32'h0000_FF00;
    @(negedge clk);
    checks++; if ({done, res} !== {1'b1, 32'h0000_F00F}) begin errors++; $display("FAIL b2b_eor: got %b/%h exp 1/f00f", done, res); end
    start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    checks++; if ({done, res, dbz} !== {1'b1, 32'h0000_F000, 1'b0}) begin errors++; $display("FAIL b2b_and: got %b/%h/%b exp 1/f000/0", done, res, dbz); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL b2b_end: got %b exp 00", {done, busy}); end
  endtask

  task automatic test_w8();
    int lat;
    do_op8(3'b000, 8'h7F, 8'h01, lat);
    checks++; if ({res8, flg8, lat} !== {8'h80, 4'b1001, 32'd1}) begin errors++; $display("FAIL w8_add: got %h/%b/%0d exp 80/1001/1", res8, flg8, lat); end
    do_op8(3'b001, 8'd3, 8'd5, lat);
    checks++; if ({res8, flg8} !== {8'hFE, 4'b1000}) begin errors++; $display("FAIL w8_sub: got %h/%b exp fe/1000", res8, flg8); end
    do_op8(3'b101, 8'hFF, 8'hFF, lat);
    checks++; if ({rhi8, res8, flg8, lat} !== {8'hFE, 8'h01, 4'b0000, 32'd8}) begin errors++; $display("FAIL w8_mul: got %h_%h/%b/%0d exp fe_01/0000/8", rhi8, res8, flg8, lat); end
    do_op8(3'b110, 8'd100, 8'd7, lat);
    checks++; if ({res8, rhi8, dbz8, lat} !== {8'd14, 8'd2, 1'b0, 32'd8}) begin errors++; $display("FAIL w8_div: got %0d r%0d z%b %0d exp 14 r2 z0 8", res8, rhi8, dbz8, lat); end
    do_op8(3'b110, 8'h12, 8'h00, lat);
    checks++; if ({res8, rhi8, dbz8, flg8} !== {8'hFF, 8'h12, 1'b1, 4'b1000}) begin errors++; $display("FAIL w8_div0: got %h r%h z%b %b exp ff r12 z1 1000", res8, rhi8, dbz8, flg8); end
    do_op8(3'b111, 8'hAA, 8'h55, lat);
    checks++; if ({res8, rhi8, flg8, dbz8} !== {16'h0, 4'b0100, 1'b0}) begin errors++; $display("FAIL w8_rsvd: got %h %h %b %b exp 0 0 0100 0", res8, rhi8, flg8, dbz8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_div();
    test_reset_mid();
    test_back_to_back();
    test_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
